// File: rtl/extractor_pkg.sv
// rtl/extractor_pkg.sv - shared types and helpers for the sign-bit extractor
package extractor_pkg;

  localparam int BYTE_BITS = 8;

  typedef enum logic [1:0] {
    LOAD,
    SEEK,
    TAKE,
    GUARD
  } ext_state_t;

  // Bit index into the held video byte; 0 addresses the MSB.
  typedef logic [2:0] cursor_t;

  // Number of unread bits from the cursor to the end of the held byte.
  function automatic logic [3:0] bits_left(input cursor_t c);
    return 4'(BYTE_BITS) - {1'b0, c};
  endfunction

endpackage

// File: rtl/extractor_bit_packer.sv
// rtl/extractor_bit_packer.sv - serial-in byte-out bit packer with flush
module bit_packer
  import extractor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       push,
  input  logic       bit_in,
  input  logic       flush,
  output logic [7:0] data_out,
  output logic       data_wr
);

  logic [7:0] acc;
  logic [7:0] acc_n;
  logic [2:0] fill;
  logic [3:0] fill_n;
  logic [3:0] pad;
  logic       wr_q;

  // Shift the incoming bit in at the LSB so the first bit ends up in the MSB.
  always_comb begin
    acc_n  = push ? {acc[6:0], bit_in} : acc;
    fill_n = {1'b0, fill} + {3'b000, push};
    pad    = 4'(BYTE_BITS) - fill_n;
  end

  // A full byte always wins over flush; flush left-aligns a partial byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      fill     <= '0;
      data_out <= '0;
      wr_q     <= 1'b0;
    end else if (en) begin
      wr_q <= 1'b0;
      if (fill_n == 4'(BYTE_BITS)) begin
        data_out <= acc_n;
        wr_q     <= 1'b1;
        acc      <= '0;
        fill     <= '0;
      end else if (flush && (fill_n != 4'd0)) begin
        data_out <= acc_n << pad;
        wr_q     <= 1'b1;
        acc      <= '0;
        fill     <= '0;
      end else begin
        acc  <= acc_n;
        fill <= fill_n[2:0];
      end
    end
  end

  assign data_wr = wr_q & en;

endmodule

// File: rtl/extractor.sv
// rtl/extractor.sv - recovers embedded sign bits from a stego video byte stream
module extractor
  import extractor_pkg::*;
#(
  parameter int CNT_W  = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] vid_in,
  input  logic              vid_empty,
  output logic              vid_rd,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              sign_flag,
  input  logic              extend_flag,
  input  logic              cnt_empty,
  output logic              cnt_rd,
  input  logic              out_afull,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic              data_wr,
  output logic              ext_err
);

  logic module_en;

  ext_state_t        state, state_n;
  logic [CNT_W-1:0]  rem, rem_n;
  logic              sf, sf_n;
  logic              ef, ef_n;
  cursor_t           cursor, cursor_n;
  logic [DATA_W-1:0] vbyte, vbyte_n;
  logic              held, held_n;
  logic              vid_wait, vid_wait_n;
  logic              cnt_wait, cnt_wait_n;
  logic              tbit, tbit_n;
  logic              err_q, err_n;
  logic              vid_fetch, cnt_fetch, push;
  logic [CNT_W-1:0]  avail;
  cursor_t           bit_sel;
  logic              cur_bit;

  assign module_en = clk_en & ~out_afull;
  assign avail     = CNT_W'(bits_left(cursor));
  assign bit_sel   = 3'd7 - cursor;
  assign cur_bit   = vbyte[bit_sel];

  // Next-state logic: FIFO data arrives the cycle after its read strobe.
  always_comb begin
    state_n    = state;
    rem_n      = rem;
    sf_n       = sf;
    ef_n       = ef;
    cursor_n   = cursor;
    vbyte_n    = vbyte;
    held_n     = held;
    vid_wait_n = vid_wait;
    cnt_wait_n = cnt_wait;
    tbit_n     = tbit;
    err_n      = 1'b0;
    vid_fetch  = 1'b0;
    cnt_fetch  = 1'b0;
    push       = 1'b0;
    case (state)
      LOAD: begin
        if (cnt_wait) begin
          rem_n      = cnt_in;
          sf_n       = sign_flag;
          ef_n       = extend_flag;
          cnt_wait_n = 1'b0;
          state_n    = SEEK;
        end else if (!cnt_empty) begin
          cnt_fetch  = 1'b1;
          cnt_wait_n = 1'b1;
        end
      end
      SEEK: begin
        if (vid_wait) begin
          vbyte_n    = vid_in;
          held_n     = 1'b1;
          vid_wait_n = 1'b0;
        end else if (!held) begin
          if (!vid_empty) begin
            vid_fetch  = 1'b1;
            vid_wait_n = 1'b1;
          end
        end else if (rem >= avail) begin
          // Skip the rest of this byte and start fetching the next one.
          rem_n    = rem - avail;
          cursor_n = '0;
          held_n   = 1'b0;
          if (!vid_empty) begin
            vid_fetch  = 1'b1;
            vid_wait_n = 1'b1;
          end
        end else begin
          cursor_n = cursor + rem[2:0];
          rem_n    = '0;
          state_n  = TAKE;
        end
      end
      TAKE: begin
        tbit_n   = cur_bit;
        push     = sf;
        cursor_n = cursor + 3'd1;
        if (cursor == 3'd7) held_n = 1'b0;
        state_n  = ef ? GUARD : LOAD;
      end
      GUARD: begin
        if (vid_wait) begin
          vbyte_n    = vid_in;
          held_n     = 1'b1;
          vid_wait_n = 1'b0;
        end else if (!held) begin
          if (!vid_empty) begin
            vid_fetch  = 1'b1;
            vid_wait_n = 1'b1;
          end
        end else begin
          // The guard must be the complement of the taken bit.
          if (sf && (cur_bit == tbit)) err_n = 1'b1;
          cursor_n = cursor + 3'd1;
          if (cursor == 3'd7) held_n = 1'b0;
          state_n  = LOAD;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // State register; everything freezes while the module is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      rem      <= '0;
      sf       <= 1'b0;
      ef       <= 1'b0;
      cursor   <= '0;
      vbyte    <= '0;
      held     <= 1'b0;
      vid_wait <= 1'b0;
      cnt_wait <= 1'b0;
      tbit     <= 1'b0;
      err_q    <= 1'b0;
    end else if (module_en) begin
      state    <= state_n;
      rem      <= rem_n;
      sf       <= sf_n;
      ef       <= ef_n;
      cursor   <= cursor_n;
      vbyte    <= vbyte_n;
      held     <= held_n;
      vid_wait <= vid_wait_n;
      cnt_wait <= cnt_wait_n;
      tbit     <= tbit_n;
      err_q    <= err_n;
    end
  end

  assign vid_rd  = vid_fetch & module_en & ~rst;
  assign cnt_rd  = cnt_fetch & module_en & ~rst;
  assign ext_err = err_q & module_en;

  bit_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .en       (module_en),
    .push     (push),
    .bit_in   (cur_bit),
    .flush    (flush),
    .data_out (data_out),
    .data_wr  (data_wr)
  );

endmodule

// File: tb/tb_extractor.sv
// tb/tb_extractor.sv - directed self-checking bench for extractor
module tb_extractor;

  logic       clk, rst, clk_en;
  logic [7:0] vid_in;
  logic       vid_empty, vid_rd;
  logic [6:0] cnt_in;
  logic       sign_flag, extend_flag, cnt_empty, cnt_rd;
  logic       out_afull, flush;
  logic [7:0] data_out;
  logic       data_wr, ext_err;

  logic [7:0] vq[$];
  logic [8:0] cq[$];
  logic [7:0] got[$];
  int n_vrd, n_crd, n_err, n_stall;
  int total, bad;

  extractor dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .vid_in     (vid_in),
    .vid_empty  (vid_empty),
    .vid_rd     (vid_rd),
    .cnt_in     (cnt_in),
    .sign_flag  (sign_flag),
    .extend_flag(extend_flag),
    .cnt_empty  (cnt_empty),
    .cnt_rd     (cnt_rd),
    .out_afull  (out_afull),
    .flush      (flush),
    .data_out   (data_out),
    .data_wr    (data_wr),
    .ext_err    (ext_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mk(input int c, input bit s, input bit e);
    return {7'(c), s, e};
  endfunction

  function automatic logic [7:0] out_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  // One clock: drive empties, sample away from the edge, model the FIFOs.
  task automatic tick();
    logic rv, rc;
    logic [8:0] e;
    @(negedge clk);
    vid_empty = (vq.size() == 0);
    cnt_empty = (cq.size() == 0);
    #1;
    rv = vid_rd;
    rc = cnt_rd;
    if (vid_rd) n_vrd++;
    if (cnt_rd) n_crd++;
    if (data_wr) got.push_back(data_out);
    if (ext_err) n_err++;
    if ((!clk_en || out_afull) && (vid_rd || cnt_rd || data_wr || ext_err)) n_stall++;
    @(posedge clk);
    #1;
    if (rv) vid_in = vq.pop_front();
    if (rc) begin
      e = cq.pop_front();
      cnt_in      = e[8:2];
      sign_flag   = e[1];
      extend_flag = e[0];
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_out(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (got.size() < n) check({tag, "_timeout"}, got.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_en = 1'b1; out_afull = 1'b0; flush = 1'b0;
    vid_in = '0; cnt_in = '0; sign_flag = 1'b0; extend_flag = 1'b0;
    vid_empty = 1'b1; cnt_empty = 1'b1;
    vq.delete(); cq.delete(); got.delete();
    n_vrd = 0; n_crd = 0; n_err = 0; n_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic walk(input int n);
    repeat (n) cq.push_back(mk(0, 1, 0));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;

    // Reset state, with FIFOs claiming data so the strobes are exercised.
    rst = 1'b1; clk_en = 1'b1; out_afull = 1'b0; flush = 1'b0;
    vid_in = '0; cnt_in = '0; sign_flag = 1'b0; extend_flag = 1'b0;
    vid_empty = 1'b0; cnt_empty = 1'b0;
    #12;
    check("rst_cnt_rd", cnt_rd, 0);
    check("rst_vid_rd", vid_rd, 0);
    check("rst_data_wr", data_wr, 0);
    check("rst_ext_err", ext_err, 0);
    check("rst_data_out", data_out, 0);

    // Cursor walk over one byte; a ninth non-sign entry forces a second fetch.
    do_reset();
    vq.push_back(8'hA5); vq.push_back(8'h00);
    walk(8); cq.push_back(mk(0, 0, 0));
    wait_out(1, 200, "walk");
    run(20);
    check("walk_data", out_at(0), 8'hA5);
    check("walk_nwr", got.size(), 1);
    check("walk_vid_rd", n_vrd, 2);

    // Skip 19 repeatedly over 0x10 bytes: bits alternate 1,0.
    do_reset();
    vq.push_back(8'h00); vq.push_back(8'h00);
    repeat (18) vq.push_back(8'h10);
    repeat (8) cq.push_back(mk(19, 1, 0));
    wait_out(1, 600, "skip19");
    run(10);
    check("skip19_data", out_at(0), 8'hAA);
    check("skip19_vid_rd", n_vrd, 20);

    // Skip 127 lands on byte 15 bit 7, then seven bits of 0x5A.
    do_reset();
    repeat (15) vq.push_back(8'h00);
    vq.push_back(8'h01); vq.push_back(8'h5A);
    cq.push_back(mk(127, 1, 0));
    walk(7);
    wait_out(1, 600, "skip127");
    run(10);
    check("skip127_data", out_at(0), 8'hAD);
    check("skip127_vid_rd", n_vrd, 17);

    // Guard across a byte boundary, correct complement.
    do_reset();
    vq.push_back(8'h01); vq.push_back(8'h7F);
    cq.push_back(mk(7, 1, 1));
    run(30);
    check("guard_ok_err", n_err, 0);
    pulse_flush();
    run(3);
    check("guard_ok_flush", out_at(0), 8'h80);

    // Guard mismatch gives exactly one pulse.
    do_reset();
    vq.push_back(8'h01); vq.push_back(8'hFF);
    cq.push_back(mk(7, 1, 1));
    run(30);
    check("guard_bad_err", n_err, 1);

    // Guard with sf=0: check suppressed but the guard bit is still skipped.
    do_reset();
    vq.push_back(8'h01); vq.push_back(8'hBF);
    cq.push_back(mk(7, 0, 1)); cq.push_back(mk(0, 1, 0));
    run(40);
    check("guard_nosf_err", n_err, 0);
    pulse_flush();
    run(3);
    check("guard_nosf_nwr", got.size(), 1);
    check("guard_nosf_data", out_at(0), 8'h00);

    // Backpressure and clock-enable stall mid-stream.
    do_reset();
    vq.push_back(8'h3C); vq.push_back(8'hC3);
    walk(16);
    run(20);
    out_afull = 1'b1;
    run(5);
    out_afull = 1'b0;
    run(3);
    clk_en = 1'b0;
    run(3);
    clk_en = 1'b1;
    wait_out(2, 300, "stall");
    check("stall_activity", n_stall, 0);
    check("stall_byte0", out_at(0), 8'h3C);
    check("stall_byte1", out_at(1), 8'hC3);

    // Empty count FIFO stall, then flush of three bits.
    do_reset();
    vq.push_back(8'hA0);
    walk(1);
    run(25);
    check("empty_nwr", got.size(), 0);
    walk(2);
    run(20);
    check("preflush_nwr", got.size(), 0);
    pulse_flush();
    run(3);
    check("flush_data", out_at(0), 8'hA0);
    pulse_flush();
    run(3);
    check("flush_empty_nwr", got.size(), 1);

    // Asynchronous reset while seeking through a long skip.
    do_reset();
    vq.push_back(8'h5A);
    repeat (20) vq.push_back(8'h00);
    walk(8);
    cq.push_back(mk(127, 1, 0));
    wait_out(1, 200, "prerst");
    check("prerst_data", out_at(0), 8'h5A);
    run(6);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_vid_rd", vid_rd, 0);
    check("arst_cnt_rd", cnt_rd, 0);
    check("arst_data_wr", data_wr, 0);
    check("arst_ext_err", ext_err, 0);
    check("arst_data_out", data_out, 0);
    do_reset();
    vq.push_back(8'h96);
    walk(8);
    wait_out(1, 200, "postrst");
    run(10);
    check("postrst_data", out_at(0), 8'h96);
    check("postrst_nwr", got.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/extractor.md
Name: extractor

Overview:
- Receive-side counterpart of the bit-replacement embedder: recovers embedded sign bits from a stego video byte stream.
- Consumes a video byte FIFO and a skip-count FIFO (count + sign_flag + extend_flag), walks the video bits MSB-first and picks each sign bit out at its position.
- Verifies the complement guard bit that follows an extended sign.
- Repacks recovered bits into bytes for the output FIFO. Sits between the video-in FIFOs and the message-out FIFO.

Parameters:
- CNT_W, 7, width of skip count.
- DATA_W, 8, video and output byte width; cursor arithmetic assumes 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- clk_en  in  1  global enable.
- vid_in  in  8  video byte, valid the cycle after vid_rd.
- vid_empty  in  1  video FIFO empty.
- vid_rd  out  1  video FIFO read strobe.
- cnt_in  in  7  bits to skip before the target bit.
- sign_flag  in  1  target bit carries a sign bit.
- extend_flag  in  1  bit after the target is the complement guard bit.
- cnt_empty  in  1  count FIFO empty.
- cnt_rd  out  1  count FIFO read strobe.
- out_afull  in  1  output FIFO almost full.
- flush  in  1  pulse: emit a partial output byte, zero-padded.
- data_out  out  8  packed sign bits, first bit in MSB.
- data_wr  out  1  output FIFO write strobe.
- ext_err  out  1  one-cycle pulse on guard-bit mismatch.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset: all state cleared. vid_rd, cnt_rd, data_wr and ext_err are 0; data_out is 0; cursor is 0; packer is empty; FSM is in LOAD.
- Enable: module_en = clk_en & ~out_afull. When module_en=0, all state holds, data_wr and ext_err are 0, and no FIFO reads are issued.
- FIFO model: a read strobe in cycle N means data is valid in cycle N+1. The block registers that data internally. A read is issued only when the FIFO is not empty and module_en=1.
- Cursor: bit index 0..7 into the held video byte, with index 0 at the MSB.
- FSM LOAD: issue cnt_rd, then latch rem=cnt_in, sf=sign_flag, ef=extend_flag. Go to SEEK.
- FSM SEEK: if no byte is held, issue vid_rd and wait. If rem >= 8-cursor: rem -= 8-cursor, cursor=0, drop the byte and fetch the next. Otherwise cursor += rem, rem=0, go to TAKE. At most one byte is consumed per cycle.
- FSM TAKE: bit b = byte[7-cursor].
  - If sf, push b to the packer.
  - cursor += 1. On wrap to 8, drop the byte.
  - If ef, go to GUARD; else go to LOAD.
- FSM GUARD: needs a held byte (fetch one if the byte was dropped).
  - Compare byte[7-cursor] with ~b. On mismatch, pulse ext_err the next cycle.
  - cursor += 1, with the same wrap rule. Go to LOAD.
  - ef with sf=0 still skips the guard bit, but the check is suppressed.
- Packer: shift register plus a 3-bit fill counter.
  - On the 8th bit: data_out = the byte, data_wr=1 for one cycle, counter=0.
  - Latency: the last bit in TAKE produces data_wr 1 cycle later.
  - flush with fill > 0: emit data_out = bits left-aligned, low bits 0, data_wr=1.
  - flush with fill = 0: no write.
  - flush in the same cycle as the 8th bit: the full byte is written; flush is ignored.
- Empty FIFOs: the FSM stalls in its current state with no state change. A pending count is never lost.
- Boundary cases:
  - cnt=0 takes the bit at the cursor.
  - cnt=127 spans up to 16 bytes.
  - A target at cursor 7 followed by a guard bit crosses the byte boundary.
- Reset mid-operation: immediate async clear. A partial output byte is discarded.

Decomposition:
- Shared package holds:
  - the extractor FSM state enum: LOAD, SEEK, TAKE, GUARD;
  - localparam BYTE_BITS=8;
  - the cursor type as 3-bit logic.
- One sub-module, bit_packer: serial-in / byte-out with flush. It is reusable by other bit-level stages.

Test Plan:
- Cursor walk: 8 entries cnt=0, sf=1, ef=0 over vid 0xA5 -> one data_wr with data_out=0xA5, 1 cycle after the 8th TAKE; vid_rd issued exactly twice (the second fetch happens after the byte wraps).
- Skip across bytes: vid 0x00, 0x00, 0x10, then cnt=19, sf=1, repeated to 8 bits over 0x10-patterned bytes -> first recovered bit 1. Also check rem arithmetic on a 127 skip spanning 16 bytes.
- Guard check across a byte boundary: target at cursor 7 of byte 0x01 (bit=1), next byte 0x7F (guard 0) -> no ext_err. With next byte 0xFF -> exactly one ext_err pulse.
- Backpressure: hold out_afull=1 for 5 cycles mid-stream -> no reads, no writes, state frozen; the output matches the no-stall run byte for byte.
- Flush and empty stall: 3 bits 1,0,1 then flush -> data_out=0xA0. Keep cnt_empty=1 for 10 cycles -> FSM idles and resumes correctly.
- Async reset mid-SEEK: assert rst asynchronously -> outputs 0 immediately, no data_wr. After release, a fresh stream decodes correctly.
